y86_mem_responder: RTL and testbench
====================================

Name: y86_mem_responder

Overview:
- Bus responder (memory slave) for the y86 sequential core. It answers the core's bus_A/bus_RE/bus_WE/bus_out initiator interface with zero-wait-state reads and synchronous 32-bit writes.
- Contains a byte-addressed little-endian memory and a byte-stream program loader FSM. The loader holds the core in reset until the image is loaded.
- Also keeps write statistics and a sticky address-fault flag for bench and debug observation.

Parameters:
- ADDR_BITS, 10, log2 of memory depth in bytes (DEPTH = 2**ADDR_BITS = 1024).
- CNT_BITS, 16, width of the saturating write counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- bus_A  in  32  byte address from the core.
- bus_RE  in  1  read enable from the core.
- bus_WE  in  1  write enable from the core.
- bus_out  in  32  write data from the core.
- bus_in  out  32  read data to the core (combinational).
- cpu_rst  out  1  registered reset to the core.
- ld_start  in  1  pulse that begins or restarts image loading.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_last  in  1  marks the final byte; qualified by ld_valid.
- ld_ready  out  1  loader accepts a byte this cycle.
- wr_count  out  CNT_BITS  number of accepted bus writes, saturating.
- last_wr_addr  out  32  bus_A of the most recent accepted write.
- fault  out  1  sticky out-of-range access flag.
- ld_ovf  out  1  sticky flag: loader pointer wrapped past DEPTH-1.

Behaviour:
- FSM states: IDLE, LOAD, RUN. rst forces IDLE.
- Reset values: cpu_rst=1, ld_ready=0, wr_count=0, last_wr_addr=0, fault=0, ld_ovf=0, loader pointer=0. Memory contents are not reset.
- IDLE: cpu_rst=1, ld_ready=0. ld_start moves to LOAD.
- LOAD: ld_ready=1. Each cycle with ld_valid=1, mem[ptr] <= ld_data and ptr <= ptr+1 modulo DEPTH. A wrap from DEPTH-1 to 0 sets ld_ovf. ld_valid&ld_last writes the byte and moves to RUN. ld_start in LOAD restarts the load: ptr <= 0, the byte in that cycle is not written.
- Entry to LOAD (from any state): ptr <= 0, fault <= 0, ld_ovf <= 0, wr_count <= 0.
- RUN: cpu_rst=0, registered, so it deasserts in the cycle after the transition. ld_ready=0. ld_start moves to LOAD and cpu_rst is 1 from the next cycle. Loader bytes are ignored in RUN.
- In-range access: bus_A < DEPTH. Out-of-range access: bus_A >= DEPTH with bus_RE or bus_WE high in RUN. An out-of-range access sets fault, reads return 0 and writes are dropped.
- Read (RUN, bus_RE, in range): bus_in = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, same cycle, zero latency. Indices a+k wrap modulo DEPTH. Unaligned addresses are legal, since the core fetches at arbitrary byte IP.
- bus_in = 0 when bus_RE=0, when not in RUN, or when out of range.
- Write (RUN, bus_WE, in range): at the clock edge, mem[a+k] <= bus_out[8k+7:8k] for k=0..3, with wrap modulo DEPTH. Same edge: last_wr_addr <= bus_A, and wr_count increments, saturating at all-ones.
- bus_RE and bus_WE together: the read returns pre-write data and the write lands at the edge.
- Bus accesses outside RUN are ignored: no memory update, no fault, no count.
- rst mid-load: loader state is lost, the FSM returns to IDLE with cpu_rst=1, and the partial image stays in memory.

Test Plan:
- Load bytes 8B 45 08 (ld_last on byte 3) -> ld_ready high for 3 accepted bytes, then RUN. cpu_rst falls one cycle after the last byte. Read bus_A=0 with bus_RE=1 -> bus_in=0xXX08458B, where the top byte is the old content of mem[3].
- RUN, bus_WE=1, bus_A=0x10, bus_out=0xDEADBEEF -> next cycle a read at 0x10 returns 0xDEADBEEF and a read at 0x11 returns {mem[0x14], 0xDE, 0xAD, 0xBE}. wr_count=1, last_wr_addr=0x10.
- Wrap: write 0x11223344 at 0x3FE -> mem[0x3FE]=0x44, mem[0x3FF]=0x33, mem[0]=0x22, mem[1]=0x11. A read at 0x3FE returns 0x11223344.
- Read at 0x400 in RUN -> bus_in=0 and fault=1 on the next cycle, holding. A write at 0x400 leaves memory and wr_count unchanged. ld_start clears fault.
- Loader: 1025 bytes with ld_last on the final byte -> ld_ovf=1 and mem[0] holds byte 1025. Separately, rst asserted mid-load -> IDLE, cpu_rst=1, ld_ready=0.
- Same-cycle RE+WE at 0x20 (old data 0x0, bus_out 0x5) -> bus_in=0 in that cycle and 0x5 on a read in the next cycle. Driving 65537 writes -> wr_count holds at 0xFFFF.

Source files
------------

// File: rtl/y86_mem_responder_if.sv
// Core-to-memory bus of the y86 sequential core: byte address, read/write
// strobes, write data from the core and combinational read data back.
interface y86_mem_responder_if;
  logic [31:0] bus_A;
  logic        bus_RE;
  logic        bus_WE;
  logic [31:0] bus_out;
  logic [31:0] bus_in;

  modport master (output bus_A, bus_RE, bus_WE, bus_out, input bus_in);
  modport slave  (input bus_A, bus_RE, bus_WE, bus_out, output bus_in);
endinterface

// File: rtl/y86_mem_responder.sv
// Memory slave for the y86 core: zero-wait reads, 32-bit writes, byte-stream
// image loader that holds the core in reset, plus write/fault statistics.
module y86_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  y86_mem_responder_if.slave   bus,
  output logic                 cpu_rst,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic [CNT_BITS-1:0]  wr_count,
  output logic [31:0]          last_wr_addr,
  output logic                 fault,
  output logic                 ld_ovf
);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  fault_q, fault_d;
  logic                  ld_ovf_q, ld_ovf_d;
  logic [CNT_BITS-1:0]   wr_count_q, wr_count_d;
  logic [31:0]           last_wr_addr_q, last_wr_addr_d;
  logic [7:0]            mem_q [DEPTH];

  logic                  in_range;
  logic                  bus_wr;
  logic                  ld_wr;
  logic [ADDR_BITS-1:0]  addr_k [4];

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign in_range = (bus.bus_A[31:ADDR_BITS] == '0);

  // Byte lanes of a word access wrap around the top of memory.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      addr_k[k] = bus.bus_A[ADDR_BITS-1:0] + ADDR_BITS'(k);
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    fault_d        = fault_q;
    ld_ovf_d       = ld_ovf_q;
    wr_count_d     = wr_count_q;
    last_wr_addr_d = last_wr_addr_q;
    ld_wr          = 1'b0;
    bus_wr         = 1'b0;
    case (state_q)
      IDLE: ;
      LOAD: begin
        if (!ld_start && ld_valid) begin
          ld_wr = 1'b1;
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == '1) ld_ovf_d = 1'b1;
          if (ld_last) state_d = RUN;
        end
      end
      RUN: begin
        if ((bus.bus_RE || bus.bus_WE) && !in_range) fault_d = 1'b1;
        if (bus.bus_WE && in_range) begin
          bus_wr         = 1'b1;
          last_wr_addr_d = bus.bus_A;
          wr_count_d     = sat_inc(wr_count_q);
        end
      end
      default: state_d = IDLE;
    endcase
    // ld_start (re)enters LOAD from any state and clears the per-image statistics.
    if (ld_start) begin
      state_d    = LOAD;
      ptr_d      = '0;
      fault_d    = 1'b0;
      ld_ovf_d   = 1'b0;
      wr_count_d = '0;
    end
    cpu_rst_d = (state_d != RUN);
  end

  always_comb begin
    bus.bus_in = '0;
    if (state_q == RUN && bus.bus_RE && in_range) begin
      bus.bus_in = {mem_q[addr_k[3]], mem_q[addr_k[2]], mem_q[addr_k[1]], mem_q[addr_k[0]]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      cpu_rst_q      <= 1'b1;
      fault_q        <= 1'b0;
      ld_ovf_q       <= 1'b0;
      wr_count_q     <= '0;
      last_wr_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cpu_rst_q      <= cpu_rst_d;
      fault_q        <= fault_d;
      ld_ovf_q       <= ld_ovf_d;
      wr_count_q     <= wr_count_d;
      last_wr_addr_q <= last_wr_addr_d;
    end
  end

  // Memory contents survive reset so a partial image stays visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ld_wr) mem_q[ptr_q] <= ld_data;
      if (bus_wr) begin
        for (int k = 0; k < 4; k++) begin
          mem_q[addr_k[k]] <= bus.bus_out[8*k +: 8];
        end
      end
    end
  end

  assign cpu_rst      = cpu_rst_q;
  assign ld_ready     = (state_q == LOAD);
  assign wr_count     = wr_count_q;
  assign last_wr_addr = last_wr_addr_q;
  assign fault        = fault_q;
  assign ld_ovf       = ld_ovf_q;
endmodule

// File: tb/tb_y86_mem_responder.sv
// Directed bench for y86_mem_responder: a byte-level reference memory yields
// expected reads, queued at drive time and compared when the DUT answers.
module tb_y86_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rst;
  logic        ld_start, ld_valid, ld_last;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic [15:0] wr_count;
  logic [31:0] last_wr_addr;
  logic        fault, ld_ovf;

  always #5 clk = ~clk;

  y86_mem_responder_if bus ();

  y86_mem_responder #(.ADDR_BITS(10), .CNT_BITS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cpu_rst      (cpu_rst),
    .ld_start     (ld_start),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .wr_count     (wr_count),
    .last_wr_addr (last_wr_addr),
    .fault        (fault),
    .ld_ovf       (ld_ovf)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
    logic [31:0] mask;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [7:0]  mdl [1024];
  logic        kn  [1024];
  int          ptr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_exp(input string tag, input logic [31:0] exp,
                                   input logic [31:0] mask);
    exp_t e;
    e.tag  = tag;
    e.exp  = exp;
    e.mask = mask;
    sb.push_back(e);
  endfunction

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed=%h expected=<nothing queued>", obs);
    end else begin
      e = sb.pop_front();
      assert ((obs & e.mask) === (e.exp & e.mask)) else begin
        n_err++;
        $error("FAIL %s: observed=%h expected=%h (mask %h)", e.tag, obs, e.exp, e.mask);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push_exp(tag, exp, 32'hFFFF_FFFF);
    pop_check(obs);
  endtask

  function automatic void mread(input int a, output logic [31:0] v, output logic [31:0] m);
    for (int k = 0; k < 4; k++) begin
      v[8*k +: 8] = mdl[(a + k) % 1024];
      m[8*k +: 8] = kn[(a + k) % 1024] ? 8'hFF : 8'h00;
    end
  endfunction

  function automatic void mwrite(input int a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) begin
      mdl[(a + k) % 1024] = d[8*k +: 8];
      kn[(a + k) % 1024]  = 1'b1;
    end
  endfunction

  // Single-cycle read in RUN; out-of-range addresses must read as zero.
  task automatic bus_read(input string tag, input int a);
    logic [31:0] v, m;
    if (a >= 1024) begin
      v = 32'h0;
      m = 32'hFFFF_FFFF;
    end else begin
      mread(a, v, m);
    end
    bus.bus_A  = 32'(a);
    bus.bus_RE = 1'b1;
    bus.bus_WE = 1'b0;
    push_exp(tag, v, m);
    #3;
    pop_check(bus.bus_in);
    tick();
    bus.bus_RE = 1'b0;
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    bus.bus_A   = 32'(a);
    bus.bus_out = d;
    bus.bus_WE  = 1'b1;
    bus.bus_RE  = 1'b0;
    tick();
    bus.bus_WE  = 1'b0;
    if (a < 1024) mwrite(a, d);
  endtask

  task automatic ld_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    push_exp("ld_ready_in_load", 32'h1, 32'hFFFF_FFFF);
    #3;
    pop_check(32'(ld_ready));
    if (last) chk("cpu_rst_during_last_byte", 32'(cpu_rst), 32'h1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    mdl[ptr] = d;
    kn[ptr]  = 1'b1;
    ptr      = (ptr + 1) % 1024;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ptr      = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mdl[i] = 8'h00;
      kn[i]  = 1'b0;
    end
    ptr         = 0;
    rst         = 1'b1;
    ld_start    = 1'b0;
    ld_valid    = 1'b0;
    ld_last     = 1'b0;
    ld_data     = 8'h00;
    bus.bus_A   = '0;
    bus.bus_RE  = 1'b0;
    bus.bus_WE  = 1'b0;
    bus.bus_out = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and bus inertness outside RUN.
    chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("rst_ld_ready", 32'(ld_ready), 32'h0);
    chk("rst_wr_count", 32'(wr_count), 32'h0);
    chk("rst_last_wr_addr", last_wr_addr, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_ld_ovf", 32'(ld_ovf), 32'h0);
    bus.bus_A  = 32'h400;
    bus.bus_RE = 1'b1;
    bus.bus_WE = 1'b1;
    #3;
    chk("idle_bus_in_zero", bus.bus_in, 32'h0);
    tick();
    bus.bus_RE = 1'b0;
    bus.bus_WE = 1'b0;
    chk("idle_no_count", 32'(wr_count), 32'h0);
    chk("idle_no_fault", 32'(fault), 32'h0);

    // Three-byte image.
    pulse_start();
    chk("load_ld_ready", 32'(ld_ready), 32'h1);
    chk("load_cpu_rst", 32'(cpu_rst), 32'h1);
    ld_byte(8'h8B, 1'b0);
    ld_byte(8'h45, 1'b0);
    ld_byte(8'h08, 1'b1);
    chk("run_cpu_rst_low", 32'(cpu_rst), 32'h0);
    chk("run_ld_ready_low", 32'(ld_ready), 32'h0);
    bus_read("rd_image_0", 0);

    // Basic write and unaligned read.
    bus_write(32'h10, 32'hDEAD_BEEF);
    chk("wr_count_1", 32'(wr_count), 32'h1);
    chk("last_wr_addr_10", last_wr_addr, 32'h10);
    bus_read("rd_10", 32'h10);
    bus_read("rd_11_unaligned", 32'h11);

    // Word write wrapping past the top of memory.
    bus_write(32'h3FE, 32'h1122_3344);
    bus_read("rd_3fe_wrap", 32'h3FE);
    bus_read("rd_0_after_wrap", 0);

    // Loader bytes are ignored in RUN.
    ld_valid = 1'b1;
    ld_data  = 8'hFF;
    tick();
    ld_valid = 1'b0;
    bus_read("rd_0_ld_ignored", 0);

    // Out-of-range accesses.
    chk("fault_before", 32'(fault), 32'h0);
    bus_read("rd_400_zero", 32'h400);
    chk("fault_set", 32'(fault), 32'h1);
    tick();
    chk("fault_sticky", 32'(fault), 32'h1);
    bus_write(32'h400, 32'hAABB_CCDD);
    chk("oor_wr_count", 32'(wr_count), 32'h2);
    chk("oor_last_wr_addr", last_wr_addr, 32'h3FE);
    bus_read("rd_0_oor_dropped", 0);

    // Same-cycle read and write.
    bus_write(32'h20, 32'h0);
    bus.bus_A   = 32'h20;
    bus.bus_out = 32'h5;
    bus.bus_RE  = 1'b1;
    bus.bus_WE  = 1'b1;
    #3;
    chk("rdwr_pre_write", bus.bus_in, 32'h0);
    tick();
    bus.bus_RE = 1'b0;
    bus.bus_WE = 1'b0;
    mwrite(32'h20, 32'h5);
    bus_read("rd_20_post_write", 32'h20);
    chk("wr_count_4", 32'(wr_count), 32'h4);

    // Reload: entry to LOAD clears statistics.
    pulse_start();
    chk("reload_fault_clr", 32'(fault), 32'h0);
    chk("reload_wr_count_clr", 32'(wr_count), 32'h0);
    chk("reload_cpu_rst", 32'(cpu_rst), 32'h1);

    // Restart mid-load, then a 1025-byte image overflowing the pointer.
    ld_byte(8'h11, 1'b0);
    ld_byte(8'h22, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 8'h99;
    pulse_start();
    ld_valid = 1'b0;
    for (int i = 0; i < 1025; i++) begin
      if (i == 1023) chk("ld_ovf_before_wrap", 32'(ld_ovf), 32'h0);
      ld_byte(8'(i * 7 + 3), (i == 1024));
    end
    chk("ld_ovf_set", 32'(ld_ovf), 32'h1);
    chk("big_load_run", 32'(cpu_rst), 32'h0);
    bus_read("rd_0_byte1025", 0);
    bus_read("rd_200_image", 32'h200);

    // Write counter saturation over 65537 writes.
    bus.bus_A   = 32'h30;
    bus.bus_out = 32'hCAFE_0001;
    bus.bus_WE  = 1'b1;
    repeat (65534) tick();
    chk("wr_count_fffe", 32'(wr_count), 32'hFFFE);
    tick();
    chk("wr_count_ffff", 32'(wr_count), 32'hFFFF);
    tick();
    tick();
    bus.bus_WE = 1'b0;
    mwrite(32'h30, 32'hCAFE_0001);
    chk("wr_count_saturated", 32'(wr_count), 32'hFFFF);
    bus_read("rd_30", 32'h30);

    // Reset in the middle of a load.
    pulse_start();
    ld_byte(8'hA1, 1'b0);
    ld_byte(8'hA2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midload_rst_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("midload_rst_ld_ready", 32'(ld_ready), 32'h0);
    chk("midload_rst_wr_count", 32'(wr_count), 32'h0);
    bus.bus_A  = 32'h0;
    bus.bus_RE = 1'b1;
    #3;
    chk("midload_rst_bus_in", bus.bus_in, 32'h0);
    tick();
    bus.bus_RE = 1'b0;
    chk("midload_rst_stays_idle", 32'(ld_ready), 32'h0);

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
